dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 47 ++++
 rtl/tx_fifo.sv | 53 +++++
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes, MMIO offsets,
// STATUS bit positions and the load alignment/extension helpers.
package dmem_pkg;

   typedef enum logic [2:0] {
      RwByte  = 3'b000,
      RwHalf  = 3'b001,
      RwWord  = 3'b010,
      RwByteU = 3'b100,
      RwHalfU = 3'b101
   } rw_type_e;

   localparam logic [3:0] MmioCycleOff  = 4'h0;
   localparam logic [3:0] MmioTxOff     = 4'h4;
   localparam logic [3:0] MmioStatusOff = 4'h8;

   localparam int unsigned StFullBit  = 0;
   localparam int unsigned StEmptyBit = 1;
   localparam int unsigned StOvfBit   = 2;
   localparam int unsigned StMisBit   = 3;
   localparam int unsigned StCountLsb = 4;

   // Illegal size codes count as misaligned.
   function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
      case (rw_type_e'(t))
         RwByte, RwByteU: return 1'b0;
         RwHalf, RwHalfU: return a[0];
         RwWord:          return a != 2'b00;
         default:         return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [2:0] t);
      logic [31:0] s;
      s = w >> {lane, 3'b000};
      case (rw_type_e'(t))
         RwByte:  return {{24{s[7]}}, s[7:0]};
         RwByteU: return {24'h0, s[7:0]};
         RwHalf:  return {{16{s[15]}}, s[15:0]};
         RwHalfU: return {16'h0, s[15:0]};
         RwWord:  return w;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/tx_fifo.sv
// TX byte FIFO: power-of-two depth, registered head, push-while-full allowed only with a pop.
module tx_fifo #(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW = $clog2(DEPTH),
   localparam int unsigned CW = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [7:0]    i_data,
   input  logic          i_pop,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count,
   output logic [7:0]    o_head,
   output logic          o_ovf_evt
);
   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_pop;
   logic          w_push;

   assign o_full    = r_count == CW'(DEPTH);
   assign o_empty   = r_count == '0;
   assign o_count   = r_count;
   assign w_pop     = i_pop & ~o_empty;
   assign w_push    = i_push & (~o_full | w_pop);
   assign o_ovf_evt = i_push & o_full & ~w_pop;
   assign o_head    = o_empty ? 8'h00 : r_mem[r_rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half lane steering and combinational loads, plus a
// CYCLE/TXDATA/STATUS MMIO window feeding a TX byte FIFO.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        W_en,
   input  logic        R_en,
   input  logic [31:0] ram_addr,
   input  logic [2:0]  RW_type,
   input  logic [31:0] Wr_mem_data,
   output logic [31:0] Rd_mem_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        err
);
   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] RamBytes = 32'(DEPTH_WORDS * 4);

   logic [31:0]   r_mem [DEPTH_WORDS];
   logic [31:0]   r_cycle;
   logic          r_ovf;
   logic          r_mis;

   logic [31:0]   w_mmio_off;
   logic [31:0]   w_mmio_word;
   logic [31:0]   w_status;
   logic [31:0]   w_rd_word;
   logic [31:0]   w_wdata;
   logic [AW-1:0] w_word_idx;
   logic [3:0]    w_be;
   logic          w_is_ram, w_is_mmio, w_mapped, w_misal;
   logic          w_wr_ok, w_ram_we, w_push, w_st_wr;
   logic          w_full, w_empty, w_ovf_evt;
   logic [CW-1:0] w_count;

   assign w_is_ram   = ram_addr < RamBytes;
   assign w_mmio_off = ram_addr - MMIO_BASE;
   assign w_is_mmio  = (ram_addr >= MMIO_BASE) && (w_mmio_off < 32'd12);
   assign w_mapped   = w_is_ram | w_is_mmio;
   assign w_misal    = misaligned(RW_type, ram_addr[1:0]);
   assign w_wr_ok    = W_en & w_mapped & ~w_misal;
   assign w_ram_we   = w_wr_ok & w_is_ram;
   assign w_push     = w_wr_ok & w_is_mmio & ({w_mmio_off[3:2], 2'b00} == MmioTxOff);
   assign w_st_wr    = w_wr_ok & w_is_mmio & ({w_mmio_off[3:2], 2'b00} == MmioStatusOff);
   assign w_word_idx = ram_addr[AW+1:2];

   always_comb begin
      w_status                     = '0;
      w_status[StFullBit]          = w_full;
      w_status[StEmptyBit]         = w_empty;
      w_status[StOvfBit]           = r_ovf;
      w_status[StMisBit]           = r_mis;
      w_status[StCountLsb +: CW]   = w_count;
   end

   always_comb begin
      w_mmio_word = '0;
      case ({w_mmio_off[3:2], 2'b00})
         MmioCycleOff:  w_mmio_word = r_cycle;
         MmioTxOff:     w_mmio_word = '0;
         MmioStatusOff: w_mmio_word = w_status;
         default:       w_mmio_word = '0;
      endcase
   end

   // MMIO words are truncated from bit 0 rather than lane-shifted.
   assign w_rd_word   = w_is_ram ? r_mem[w_word_idx] : w_mmio_word;
   assign Rd_mem_data = (R_en && w_mapped && !w_misal)
                      ? load_extend(w_rd_word, w_is_ram ? ram_addr[1:0] : 2'b00, RW_type)
                      : '0;

   always_comb begin
      w_be    = 4'b0000;
      w_wdata = Wr_mem_data;
      case (rw_type_e'(RW_type))
         RwByte, RwByteU: begin
            w_be    = 4'b0001 << ram_addr[1:0];
            w_wdata = {4{Wr_mem_data[7:0]}};
         end
         RwHalf, RwHalfU: begin
            w_be    = ram_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{Wr_mem_data[15:0]}};
         end
         RwWord:  w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_ram_we && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_word_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
         end
      end
   end

   // A STATUS clear wins over a same-cycle set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle <= '0;
         r_ovf   <= 1'b0;
         r_mis   <= 1'b0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_st_wr && Wr_mem_data[StOvfBit])      r_ovf <= 1'b0;
         else if (w_ovf_evt)                        r_ovf <= 1'b1;
         if (w_st_wr && Wr_mem_data[StMisBit])      r_mis <= 1'b0;
         else if ((W_en || R_en) && w_mapped && w_misal) r_mis <= 1'b1;
      end
   end

   tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_data    (Wr_mem_data[7:0]),
      .i_pop     (tx_ready),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count),
      .o_head    (tx_data),
      .o_ovf_evt (w_ovf_evt)
   );

   assign tx_valid = ~w_empty;
   assign err      = r_ovf | r_mis;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a byte-array/queue
// reference model.
module tb_dmem_responder;
   localparam int unsigned DEPTH_WORDS = 256;
   localparam logic [31:0] BASE        = 32'h1000_0000;
   localparam int unsigned FIFO_D      = 4;
   localparam int unsigned RAM_BYTES   = DEPTH_WORDS * 4;
   localparam logic [2:0]  LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        W_en = 1'b0, R_en = 1'b0, tx_ready = 1'b0;
   logic [31:0] ram_addr = '0, Wr_mem_data = '0;
   logic [2:0]  RW_type = '0;
   logic [31:0] Rd_mem_data;
   logic        tx_valid, err;
   logic [7:0]  tx_data;

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .MMIO_BASE   (BASE),
      .FIFO_DEPTH  (FIFO_D)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .W_en        (W_en),
      .R_en        (R_en),
      .ram_addr    (ram_addr),
      .RW_type     (RW_type),
      .Wr_mem_data (Wr_mem_data),
      .Rd_mem_data (Rd_mem_data),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .err         (err)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  m_mem [RAM_BYTES];
   logic [7:0]  m_q [$];
   logic [31:0] m_cycle = '0;
   bit          m_ovf = 1'b0, m_mis = 1'b0;
   logic [2:0]  legal_types [5] = '{LB, LH, LW, LBU, LHU};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned m_size(input logic [2:0] t);
      case (t)
         LB, LBU: return 1;
         LH, LHU: return 2;
         LW:      return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_ram(input logic [31:0] a);
      return a < RAM_BYTES;
   endfunction

   function automatic bit m_mmio(input logic [31:0] a);
      return (a >= BASE) && (a - BASE < 12);
   endfunction

   function automatic bit m_bad(input logic [31:0] a, input logic [2:0] t);
      int unsigned s;
      s = m_size(t);
      return (s == 0) || ((a % s) != 0);
   endfunction

   function automatic logic [31:0] m_status();
      logic [31:0] v;
      v = 32'(m_q.size()) << 4;
      if (m_mis) v |= 32'h8;
      if (m_ovf) v |= 32'h4;
      if (m_q.size() == 0) v |= 32'h2;
      if (m_q.size() == FIFO_D) v |= 32'h1;
      return v;
   endfunction

   function automatic logic [31:0] m_load(input logic re, input logic [31:0] a, input logic [2:0] t);
      logic [31:0] v, mask;
      int unsigned s;
      if (!re || !(m_ram(a) || m_mmio(a)) || m_bad(a, t)) return 32'h0;
      s = m_size(t);
      mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
      v = '0;
      if (m_ram(a)) begin
         for (int i = 0; i < s; i++) v |= 32'(m_mem[a + i]) << (8 * i);
      end else begin
         case ((a - BASE) / 4)
            0:       v = m_cycle;
            2:       v = m_status();
            default: v = '0;
         endcase
         v &= mask;
      end
      if ((t == LB || t == LH) && v[8*s-1]) v |= ~mask;
      return v;
   endfunction

   task automatic m_update();
      bit pop, mapped, bad;
      int unsigned s;
      pop    = (m_q.size() != 0) && tx_ready;
      mapped = m_ram(ram_addr) || m_mmio(ram_addr);
      bad    = m_bad(ram_addr, RW_type);
      s      = m_size(RW_type);
      if (pop) void'(m_q.pop_front());
      if (W_en && mapped && !bad) begin
         if (m_ram(ram_addr)) begin
            for (int i = 0; i < s; i++) m_mem[ram_addr + i] = Wr_mem_data[8*i +: 8];
         end else if ((ram_addr - BASE) / 4 == 1) begin
            if (m_q.size() < FIFO_D) m_q.push_back(Wr_mem_data[7:0]);
            else m_ovf = 1'b1;
         end else if ((ram_addr - BASE) / 4 == 2) begin
            if (Wr_mem_data[2]) m_ovf = 1'b0;
            if (Wr_mem_data[3]) m_mis = 1'b0;
         end
      end
      if ((W_en || R_en) && mapped && bad) m_mis = 1'b1;
      m_cycle = m_cycle + 32'd1;
   endtask

   task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [2:0] t,
                        input logic [31:0] wd, input logic rdy);
      W_en = we; R_en = re; ram_addr = a; RW_type = t; Wr_mem_data = wd; tx_ready = rdy;
      #1;
      check("rd", Rd_mem_data, m_load(re, a, t));
      check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      check("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      check("err", 32'(err), 32'(m_ovf | m_mis));
   endtask

   task automatic tick();
      m_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cyc(input logic we, input logic re, input logic [31:0] a, input logic [2:0] t,
                      input logic [31:0] wd, input logic rdy, output logic [31:0] rd);
      drive(we, re, a, t, wd, rdy);
      rd = Rd_mem_data;
      tick();
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 65) return 32'($urandom_range(0, 63));
      if (r < 75) return 32'($urandom_range(1016, 1031));
      if (r < 95) return BASE + 32'($urandom_range(0, 15));
      return 32'h2000_0000 + 32'($urandom_range(0, 255));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, v1, v2;
      // Reset state
      @(posedge clk);
      @(negedge clk);
      drive(0, 1, BASE, LW, 0, 0);
      check("rst_cycle", Rd_mem_data, 32'h0);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      drive(0, 1, BASE + 8, LW, 0, 0);
      check("rst_status", Rd_mem_data, 32'h2);
      rst = 1'b0;
      m_cycle = '0;

      for (int w = 0; w < 16; w++) cyc(1, 0, 32'(4 * w), LW, $urandom, 0, rd);
      for (int w = 254; w < 256; w++) cyc(1, 0, 32'(4 * w), LW, $urandom, 0, rd);

      // Lane selection and extension
      cyc(1, 0, 32'h10, LW, 32'hDEAD_BEEF, 0, rd);
      cyc(0, 1, 32'h13, LB, 0, 0, rd);   check("lb13", rd, 32'hFFFF_FFDE);
      cyc(0, 1, 32'h13, LBU, 0, 0, rd);  check("lbu13", rd, 32'h0000_00DE);
      cyc(0, 1, 32'h10, LH, 0, 0, rd);   check("lh10", rd, 32'hFFFF_BEEF);
      cyc(0, 1, 32'h12, LHU, 0, 0, rd);  check("lhu12", rd, 32'h0000_DEAD);
      cyc(1, 0, 32'h11, LB, 32'h55, 0, rd);
      cyc(0, 1, 32'h10, LW, 0, 0, rd);   check("lw_after_sb", rd, 32'hDEAD_55EF);

      // Misalignment and its clear
      cyc(1, 0, 32'h12, LW, 32'h1111_1111, 0, rd);
      cyc(0, 1, 32'h11, LH, 0, 0, rd);   check("lh_misal", rd, 32'h0);
      cyc(0, 1, 32'h10, LW, 0, 0, rd);   check("misal_nowrite", rd, 32'hDEAD_55EF);
      check("err_misal", 32'(err), 32'h1);
      cyc(0, 1, BASE + 8, LW, 0, 0, rd); check("st_mis_set", 32'(rd[3]), 32'h1);
      cyc(1, 0, BASE + 8, LW, 32'h8, 0, rd);
      cyc(0, 1, BASE + 8, LW, 0, 0, rd); check("st_mis_clr", 32'(rd[3]), 32'h0);
      check("err_clr", 32'(err), 32'h0);

      // Read-before-write
      cyc(1, 1, 32'h10, LW, 32'hCAFE_F00D, 0, rd); check("rbw_old", rd, 32'hDEAD_55EF);
      cyc(0, 1, 32'h10, LW, 0, 0, rd);             check("rbw_new", rd, 32'hCAFE_F00D);

      // FIFO overflow and drain
      for (int i = 1; i <= 5; i++) begin
         cyc(1, 0, BASE + 4, LW, 32'(i), 0, rd);
         if (i == 1) check("valid_next_cycle", 32'(tx_valid), 32'h1);
      end
      cyc(0, 1, BASE + 8, LW, 0, 0, rd); check("st_full_ovf", rd, 32'h45);
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 0, LW, 0, 1);
         check("drain_order", 32'(tx_data), 32'(i));
         tick();
      end
      cyc(0, 1, BASE + 8, LW, 0, 0, rd); check("st_empty_ovf", rd, 32'h6);
      cyc(1, 0, BASE + 8, LW, 32'h4, 0, rd);
      cyc(0, 1, BASE + 8, LW, 0, 0, rd); check("st_ovf_clr", rd, 32'h2);

      // Push and pop together while full
      for (int i = 0; i < 4; i++) cyc(1, 0, BASE + 4, LW, 32'hA0 + 32'(i), 0, rd);
      cyc(1, 0, BASE + 4, LW, 32'hA4, 1, rd);
      cyc(0, 1, BASE + 8, LW, 0, 0, rd); check("st_pushpop", rd, 32'h41);
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 0, LW, 0, 1);
         check("pushpop_order", 32'(tx_data), 32'hA0 + 32'(i));
         tick();
      end

      // Cycle counter spacing and wrap
      cyc(0, 1, BASE, LW, 0, 0, v1);
      for (int i = 0; i < 39; i++) cyc(0, 0, 0, LW, 0, 0, rd);
      cyc(0, 1, BASE, LW, 0, 0, v2);
      check("cycle_delta", v2 - v1, 32'd40);
      force dut.r_cycle = 32'hFFFF_FFFF;
      m_cycle = 32'hFFFF_FFFF;
      drive(0, 1, BASE, LW, 0, 0);
      check("cycle_max", Rd_mem_data, 32'hFFFF_FFFF);
      release dut.r_cycle;
      tick();
      drive(0, 1, BASE, LW, 0, 0);
      check("cycle_wrap", Rd_mem_data, 32'h0);
      tick();

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         logic [2:0] t;
         t = ($urandom_range(0, 9) < 9) ? legal_types[$urandom_range(0, 4)] : 3'($urandom);
         cyc(1'($urandom), 1'($urandom), rand_addr(), t, $urandom, 1'($urandom), rd);
      end

      // Mid-stream reset
      cyc(1, 0, BASE + 4, LW, 32'h77, 0, rd);
      cyc(1, 0, BASE + 4, LW, 32'h78, 0, rd);
      W_en = 1'b1; R_en = 1'b1; ram_addr = BASE; RW_type = LW; Wr_mem_data = '0;
      rst = 1'b1;
      m_q.delete(); m_ovf = 1'b0; m_mis = 1'b0; m_cycle = '0;
      #1;
      check("midrst_tx_valid", 32'(tx_valid), 32'h0);
      check("midrst_cycle", Rd_mem_data, 32'h0);
      check("midrst_err", 32'(err), 32'h0);
      ram_addr = BASE + 4;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, BASE + 8, LW, 0, 0);
      check("midrst_status", Rd_mem_data, 32'h2);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
